nn_argmax_classifier: RTL

Output stage that sits directly downstream of the 5-stage neuron adder tree. It consumes one 26-bit signed neuron sum per valid cycle and forwards a ReLU-activated copy to the next layer. For the classification layer, it also tracks the running maximum over a frame of NUM_CLASSES sums and reports the winning class index with a one-cycle done pulse.

---
 rtl/nn_argmax_classifier.sv | 125 ++++++++++++
 1 files changed

// File: rtl/nn_argmax_classifier.sv
// Output stage after the neuron adder tree: a registered ReLU path to the next layer,
// plus a per-frame argmax over NUM_CLASSES signed sums with a one-cycle Done pulse.
module nn_argmax_classifier #(
  parameter int DATA_W      = 26,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = 4
) (
  input  logic              clk,
  input  logic              GlobalReset,
  input  logic              Start,
  input  logic              InValid,
  input  logic [DATA_W-1:0] InData,
  output logic              ActValid,
  output logic [DATA_W-1:0] ActData,
  output logic              Busy,
  output logic              Done,
  output logic [IDX_W-1:0]  ClassIdx,
  output logic [DATA_W-1:0] MaxValue
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DONE
  } state_e;

  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(NUM_CLASSES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   sample_cnt_q, sample_cnt_d;
  logic [DATA_W-1:0]  run_max_q, run_max_d;
  logic [IDX_W-1:0]   run_idx_q, run_idx_d;
  logic [IDX_W-1:0]   class_idx_q, class_idx_d;
  logic [DATA_W-1:0]  max_value_q, max_value_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               act_valid_q, act_valid_d;
  logic [DATA_W-1:0]  act_data_q, act_data_d;

  logic               accept;
  logic [IDX_W-1:0]   cnt_eff;
  logic               take;
  logic [DATA_W-1:0]  win_max;
  logic [IDX_W-1:0]   win_idx;

  always_comb begin
    // NOTE: every variable gets a default first so no path can leave it unassigned (no latches).
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    run_max_d    = run_max_q;
    run_idx_d    = run_idx_q;
    class_idx_d  = class_idx_q;
    max_value_d  = max_value_q;

    act_valid_d = InValid;
    act_data_d  = InData[DATA_W-1] ? '0 : InData;

    // A Start cycle behaves as slot 0 of a fresh frame, whatever state we were in.
    accept  = InValid && (Start || (state_q == ST_COLLECT));
    cnt_eff = Start ? '0 : sample_cnt_q;
    take    = (cnt_eff == '0) || ($signed(InData) > $signed(run_max_q));
    win_max = take ? InData  : run_max_q;
    win_idx = take ? cnt_eff : run_idx_q;

    if (Start) begin
      state_d      = ST_COLLECT;
      sample_cnt_d = '0;
      run_max_d    = '0;
      run_idx_d    = '0;
    end else if (state_q == ST_DONE) begin
      state_d = ST_IDLE;
    end

    if (accept) begin
      if (cnt_eff == LAST_CNT) begin
        class_idx_d  = win_idx;
        max_value_d  = win_max;
        sample_cnt_d = '0;
        state_d      = ST_DONE;
      end else begin
        sample_cnt_d = cnt_eff + IDX_W'(1);
        run_max_d    = win_max;
        run_idx_d    = win_idx;
      end
    end

    busy_d = (state_d == ST_COLLECT);
    done_d = (state_d == ST_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      state_q      <= ST_IDLE;
      sample_cnt_q <= '0;
      run_max_q    <= '0;
      run_idx_q    <= '0;
      class_idx_q  <= '0;
      max_value_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      act_valid_q  <= 1'b0;
      act_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      run_max_q    <= run_max_d;
      run_idx_q    <= run_idx_d;
      class_idx_q  <= class_idx_d;
      max_value_q  <= max_value_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      act_valid_q  <= act_valid_d;
      act_data_q   <= act_data_d;
    end
  end

  assign ActValid = act_valid_q;
  assign ActData  = act_data_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign ClassIdx = class_idx_q;
  assign MaxValue = max_value_q;

endmodule
